regfile_mp_sb: RTL and testbench

- Parametrised successor to the single-write/dual-read CPU register file.
- Adds configurable depth, width, read-port count and write-port count.
- Adds multi-write-port bypass with defined priority, and a per-register scoreboard (busy bits) with issue, writeback-clear and flush.
- Sits between decode/issue (read and issue ports) and the writeback stages (write ports) of the pipelined core.

---
 rtl/regfile_mp_sb_pkg.sv | 39 +++
 rtl/regfile_mp_sb_if.sv | 67 ++++++
 rtl/regfile_mp_sb_bypass_sel.sv | 52 +++++
 rtl/regfile_mp_sb.sv | 166 ++++++++++++++++
 tb/tb_regfile_mp_sb.sv | 398 +++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/regfile_mp_sb_pkg.sv
// ---------------------------------------------------------------------------
// regfile_pkg
//
// Shared definitions for the multi-port register file with scoreboard.
//
// Contents:
//   ZERO_REG_DEFAULT - default for "register 0 is hardwired to zero".
//   WP_XLEN_MAX      - data field width carried by wr_port_t.
//   WP_AW_MAX        - address field width carried by wr_port_t.
//   wr_port_t        - one write-port bundle {en, addr, data, clr}. The
//                      fields are sized for the largest supported
//                      configuration; users place their XLEN / AW bits in
//                      the low end and leave the rest zero.
//   calc_aw()        - register-address width for a given NREGS.
// ---------------------------------------------------------------------------
package regfile_pkg;

    localparam int ZERO_REG_DEFAULT = 1;

    // A package typedef cannot follow module parameters, so the bundle is
    // sized for the widest configuration this register file supports
    // (XLEN <= 64, NREGS <= 65536).
    localparam int WP_XLEN_MAX = 64;
    localparam int WP_AW_MAX   = 16;

    typedef struct packed {
        logic                   en;
        logic [WP_AW_MAX-1:0]   addr;
        logic [WP_XLEN_MAX-1:0] data;
        logic                   clr;
    } wr_port_t;

    // Address width for NREGS registers; never below one bit so that
    // port vectors stay legal even for degenerate sizes.
    function automatic int calc_aw(input int nregs);
        return (nregs > 1) ? $clog2(nregs) : 1;
    endfunction

endpackage

// File: rtl/regfile_mp_sb_if.sv
// ---------------------------------------------------------------------------
// regfile_mp_sb_if
//
// Bundles every non-clock/reset signal of regfile_mp_sb.
//
// Signal semantics (no back-pressure anywhere): every request is qualified
// by its enable (wr_en[i], iss_en, flush) and is consumed on the rising edge
// of clk in the cycle it is presented; the register file is always ready.
// Read ports have no enable: rd_data/rd_busy follow rd_addr combinationally.
//
// Signals:
//   wr_en    [NWR]        per-port write enable
//   wr_addr  [NWR][AW]    per-port destination register
//   wr_data  [NWR][XLEN]  per-port write data
//   wr_clr   [NWR]        write retires the pending producer (clears busy)
//   rd_addr  [NRD][AW]    per-port source register
//   rd_data  [NRD][XLEN]  per-port read data (combinational, bypassed)
//   rd_busy  [NRD]        source still waits on a producer after this cycle
//   iss_en / iss_addr     mark iss_addr busy (producer issued)
//   flush                 clear every busy bit
//   busy_vec [NREGS]      registered busy bits
//
// Modports:
//   master - decode/issue/writeback side (drives requests)
//   slave  - the register file
// ---------------------------------------------------------------------------
interface regfile_mp_sb_if
    import regfile_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int NRD   = 2,
    parameter int NWR   = 2
) ();

    localparam int AW = calc_aw(NREGS);

    logic [NWR-1:0]           wr_en;
    logic [NWR-1:0][AW-1:0]   wr_addr;
    logic [NWR-1:0][XLEN-1:0] wr_data;
    logic [NWR-1:0]           wr_clr;

    logic [NRD-1:0][AW-1:0]   rd_addr;
    logic [NRD-1:0][XLEN-1:0] rd_data;
    logic [NRD-1:0]           rd_busy;

    logic                     iss_en;
    logic [AW-1:0]            iss_addr;
    logic                     flush;

    logic [NREGS-1:0]         busy_vec;

    modport master (
        output wr_en, wr_addr, wr_data, wr_clr,
        output rd_addr,
        output iss_en, iss_addr, flush,
        input  rd_data, rd_busy, busy_vec
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, wr_clr,
        input  rd_addr,
        input  iss_en, iss_addr, flush,
        output rd_data, rd_busy, busy_vec
    );

endinterface

// File: rtl/regfile_mp_sb_bypass_sel.sv
// ---------------------------------------------------------------------------
// regfile_bypass_sel
//
// Combinational priority match of one read address against all write ports.
// When several enabled ports hit the same address the highest-index port
// supplies the data; the clear-hit flag is the OR over all matching ports
// that also carry clr.
//
// Ports:
//   rd_addr_i  [AW]         read address to match
//   wp_i       [NWR]        write-port bundles (low AW/XLEN bits meaningful)
//   hit_o                   some enabled write port targets rd_addr_i
//   data_o     [XLEN]       data of the highest-index matching port
//   clr_hit_o               some matching port also retires the producer
// ---------------------------------------------------------------------------
module regfile_bypass_sel
    import regfile_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int AW   = 5,
    parameter int NWR  = 2
) (
    input  logic [AW-1:0]           rd_addr_i,
    input  wr_port_t [NWR-1:0]      wp_i,
    output logic                    hit_o,
    output logic [XLEN-1:0]         data_o,
    output logic                    clr_hit_o
);

    // The bundle carries padding above XLEN / AW; fold it into one sink
    // so that only the meaningful bits drive logic.
    logic unused_wp;
    assign unused_wp = ^wp_i;

    always_comb begin
        hit_o     = 1'b0;
        data_o    = '0;
        clr_hit_o = 1'b0;
        // Ascending scan: a later (higher-index) match overwrites data_o,
        // which gives the highest port priority.
        for (int i = 0; i < NWR; i++) begin
            if (wp_i[i].en && (wp_i[i].addr[AW-1:0] == rd_addr_i)) begin
                hit_o  = 1'b1;
                data_o = wp_i[i].data[XLEN-1:0];
                if (wp_i[i].clr) begin
                    clr_hit_o = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/regfile_mp_sb.sv
// ---------------------------------------------------------------------------
// regfile_mp_sb
//
// Parametrised multi-read / multi-write register file with write bypass and
// a per-register scoreboard (busy bits).
//
// Parameters:
//   XLEN      data width (<= 64)
//   NREGS     number of registers, power of two, >= 2
//   NRD       read ports
//   NWR       write ports
//   ZERO_REG  1 = register 0 reads as zero, drops writes, never goes busy
//
// Ports:
//   clk   rising-edge clock for all state
//   rst   asynchronous active-low reset; clears data and busy bits and
//         forces rd_data / rd_busy / busy_vec to zero while asserted
//   rf    regfile_mp_sb_if.slave (write, read, issue, flush, busy_vec)
//
// Busy update priority per register at the clock edge:
//   flush > issue (set) > retiring write (clear) > hold.
// ---------------------------------------------------------------------------
module regfile_mp_sb
    import regfile_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int NREGS    = 32,
    parameter int NRD      = 2,
    parameter int NWR      = 2,
    parameter int ZERO_REG = ZERO_REG_DEFAULT
) (
    input  logic           clk,
    input  logic           rst,
    regfile_mp_sb_if.slave rf
);

    localparam int AW = calc_aw(NREGS);

    // True when the address is the hardwired zero register.
    function automatic logic is_r0(input logic [AW-1:0] a);
        return (ZERO_REG != 0) && (a == '0);
    endfunction

    // -----------------------------------------------------------------
    // State
    // -----------------------------------------------------------------
    logic [XLEN-1:0]  data_q [NREGS];
    logic [XLEN-1:0]  data_d [NREGS];
    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;

    // -----------------------------------------------------------------
    // Write-port bundles for the bypass selectors
    // -----------------------------------------------------------------
    wr_port_t [NWR-1:0] wp;

    always_comb begin
        for (int i = 0; i < NWR; i++) begin
            wp[i]                = '0;
            wp[i].en             = rf.wr_en[i];
            wp[i].addr[AW-1:0]   = rf.wr_addr[i];
            wp[i].data[XLEN-1:0] = rf.wr_data[i];
            wp[i].clr            = rf.wr_clr[i];
        end
    end

    // -----------------------------------------------------------------
    // Storage next state: ascending scan so the highest-index port
    // targeting an address is the one that lands.
    // -----------------------------------------------------------------
    always_comb begin
        data_d = data_q;
        for (int i = 0; i < NWR; i++) begin
            if (rf.wr_en[i] && !is_r0(rf.wr_addr[i])) begin
                data_d[rf.wr_addr[i]] = rf.wr_data[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int r = 0; r < NREGS; r++) begin
                data_q[r] <= '0;
            end
        end else begin
            data_q <= data_d;
        end
    end

    // -----------------------------------------------------------------
    // Scoreboard next state
    // -----------------------------------------------------------------
    logic [NREGS-1:0] clr_mask;
    logic [NREGS-1:0] iss_mask;

    always_comb begin
        clr_mask = '0;
        iss_mask = '0;
        busy_d   = busy_q;
        for (int i = 0; i < NWR; i++) begin
            if (rf.wr_en[i] && rf.wr_clr[i]) begin
                clr_mask[rf.wr_addr[i]] = 1'b1;
            end
        end
        if (rf.iss_en && !is_r0(rf.iss_addr)) begin
            iss_mask[rf.iss_addr] = 1'b1;
        end
        // Issue is OR-ed in after the clear so a new producer supersedes a
        // same-cycle retirement; flush overrides both.
        if (rf.flush) begin
            busy_d = '0;
        end else begin
            busy_d = (busy_q & ~clr_mask) | iss_mask;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign rf.busy_vec = busy_q;

    // -----------------------------------------------------------------
    // Read ports
    // -----------------------------------------------------------------
    logic [NRD-1:0]           byp_hit;
    logic [NRD-1:0][XLEN-1:0] byp_data;
    logic [NRD-1:0]           byp_clr;
    logic [NRD-1:0][XLEN-1:0] rd_data_c;
    logic [NRD-1:0]           rd_busy_c;

    for (genvar j = 0; j < NRD; j++) begin : g_rd
        regfile_bypass_sel #(
            .XLEN (XLEN),
            .AW   (AW),
            .NWR  (NWR)
        ) u_bypass_sel (
            .rd_addr_i (rf.rd_addr[j]),
            .wp_i      (wp),
            .hit_o     (byp_hit[j]),
            .data_o    (byp_data[j]),
            .clr_hit_o (byp_clr[j])
        );
    end

    // While reset is asserted the bypass path is gated off so the outputs
    // are zero regardless of write traffic on the bus.
    always_comb begin
        for (int j = 0; j < NRD; j++) begin
            rd_data_c[j] = '0;
            rd_busy_c[j] = 1'b0;
            if (rst && !is_r0(rf.rd_addr[j])) begin
                rd_data_c[j] = byp_hit[j] ? byp_data[j] : data_q[rf.rd_addr[j]];
                rd_busy_c[j] = busy_q[rf.rd_addr[j]] && !byp_clr[j];
            end
        end
    end

    assign rf.rd_data = rd_data_c;
    assign rf.rd_busy = rd_busy_c;

endmodule

// File: tb/tb_regfile_mp_sb.sv
// ---------------------------------------------------------------------------
// tb_regfile_mp_sb
//
// Directed scenarios followed by randomized traffic, all checked against a
// behavioural model of the register file (an array of values, an array of
// busy flags, and "last writer wins" / "issue beats retire" rules).
// Inputs change just after the falling edge; outputs are sampled 1 ns later.
// ---------------------------------------------------------------------------
module tb_regfile_mp_sb;
    import regfile_pkg::*;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int NRD   = 2;
    localparam int NWR   = 2;
    localparam int AW    = 5;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    regfile_mp_sb_if #(
        .XLEN  (XLEN),
        .NREGS (NREGS),
        .NRD   (NRD),
        .NWR   (NWR)
    ) rf ();

    regfile_mp_sb #(
        .XLEN     (XLEN),
        .NREGS    (NREGS),
        .NRD      (NRD),
        .NWR      (NWR),
        .ZERO_REG (1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .rf  (rf)
    );

    // ---------------- scoreboard state ----------------
    int n_vec = 0;
    int n_err = 0;
    logic [XLEN-1:0] exp_q[$];

    logic [XLEN-1:0] mdl_data [NREGS];
    logic            mdl_busy [NREGS];

    // ---------------- reference model ----------------
    task automatic mdl_reset();
        for (int r = 0; r < NREGS; r++) begin
            mdl_data[r] = '0;
            mdl_busy[r] = 1'b0;
        end
    endtask

    function automatic logic [XLEN-1:0] mdl_rd(input logic [AW-1:0] a);
        if (!rst || a == 0) return '0;
        for (int i = NWR - 1; i >= 0; i--) begin
            if (rf.wr_en[i] && rf.wr_addr[i] == a) return rf.wr_data[i];
        end
        return mdl_data[a];
    endfunction

    function automatic logic mdl_rbusy(input logic [AW-1:0] a);
        if (!rst || a == 0) return 1'b0;
        for (int i = 0; i < NWR; i++) begin
            if (rf.wr_en[i] && rf.wr_clr[i] && rf.wr_addr[i] == a) return 1'b0;
        end
        return mdl_busy[a];
    endfunction

    function automatic logic [NREGS-1:0] mdl_bvec();
        logic [NREGS-1:0] v;
        for (int r = 0; r < NREGS; r++) v[r] = mdl_busy[r];
        return v;
    endfunction

    // Apply one clock edge to the model using the inputs currently driven.
    task automatic mdl_clock();
        if (!rst) begin
            mdl_reset();
            return;
        end
        for (int r = 1; r < NREGS; r++) begin
            if (rf.flush) begin
                mdl_busy[r] = 1'b0;
            end else if (rf.iss_en && rf.iss_addr == AW'(r)) begin
                mdl_busy[r] = 1'b1;
            end else begin
                for (int i = 0; i < NWR; i++) begin
                    if (rf.wr_en[i] && rf.wr_clr[i] && rf.wr_addr[i] == AW'(r)) mdl_busy[r] = 1'b0;
                end
            end
            for (int i = NWR - 1; i >= 0; i--) begin
                if (rf.wr_en[i] && rf.wr_addr[i] == AW'(r)) begin
                    mdl_data[r] = rf.wr_data[i];
                    break;
                end
            end
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive_idle();
        rf.wr_en    = '0;
        rf.wr_addr  = '0;
        rf.wr_data  = '0;
        rf.wr_clr   = '0;
        rf.rd_addr  = '0;
        rf.iss_en   = 1'b0;
        rf.iss_addr = '0;
        rf.flush    = 1'b0;
    endtask

    task automatic drive_wr(input int p, input logic [AW-1:0] a, input logic [XLEN-1:0] d,
                            input logic c);
        rf.wr_en[p]   = 1'b1;
        rf.wr_addr[p] = a;
        rf.wr_data[p] = d;
        rf.wr_clr[p]  = c;
    endtask

    task automatic drive_iss(input logic [AW-1:0] a);
        rf.iss_en   = 1'b1;
        rf.iss_addr = a;
    endtask

    // Called between falling and rising edge; returns just after the next
    // falling edge with the model advanced by one clock.
    task automatic tick();
        @(posedge clk);
        mdl_clock();
        @(negedge clk);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        // power-on reset
        drive_idle();
        mdl_reset();
        rf.rd_addr[0] = 5'd5;
        @(negedge clk);
        #1;
        n_vec++;
        if (rf.busy_vec !== '0 || rf.rd_data[0] !== '0) begin
            n_err++;
            $display("FAIL por_state busy_vec=%h rd_data=%h required 0/0", rf.busy_vec, rf.rd_data[0]);
        end
        @(negedge clk);
        rst = 1'b1;
        // x5 = DEADBEEF and busy
        drive_wr(0, 5'd5, 32'hDEAD_BEEF, 1'b0);
        drive_iss(5'd5);
        tick();
        drive_idle();
        rf.rd_addr[0] = 5'd5;
        #1;
        n_vec++;
        if (rf.rd_data[0] !== 32'hDEAD_BEEF || rf.busy_vec[5] !== 1'b1) begin
            n_err++;
            $display("FAIL pre_reset rd_data=%h busy5=%b required deadbeef/1", rf.rd_data[0], rf.busy_vec[5]);
        end
        // mid-cycle asynchronous reset, with traffic on the bus
        #1;
        drive_wr(0, 5'd5, 32'h0000_0077, 1'b0);
        drive_iss(5'd6);
        rst = 1'b0;
        mdl_reset();
        #1;
        n_vec++;
        if (rf.rd_data[0] !== '0 || rf.busy_vec !== '0 || rf.rd_busy[0] !== 1'b0) begin
            n_err++;
            $display("FAIL reset_async rd_data=%h busy_vec=%h rd_busy=%b required 0", rf.rd_data[0], rf.busy_vec, rf.rd_busy[0]);
        end
        @(posedge clk);
        @(negedge clk);
        drive_idle();
        rf.rd_addr[0] = 5'd5;
        rst = 1'b1;
        #1;
        n_vec++;
        if (rf.rd_data[0] !== '0 || rf.busy_vec !== '0) begin
            n_err++;
            $display("FAIL reset_release rd_data=%h busy_vec=%h required 0", rf.rd_data[0], rf.busy_vec);
        end
        tick();
        #1;
        n_vec++;
        if (rf.rd_data[0] !== '0 || rf.busy_vec !== '0) begin
            n_err++;
            $display("FAIL reset_after rd_data=%h busy_vec=%h required 0", rf.rd_data[0], rf.busy_vec);
        end
    endtask

    task automatic test_forward();
        drive_idle();
        drive_wr(0, 5'd7, 32'h0000_1234, 1'b0);
        rf.rd_addr[0] = 5'd7;
        rf.rd_addr[1] = 5'd7;
        #1;
        n_vec++;
        if (rf.rd_data[0] !== 32'h1234 || rf.rd_data[1] !== 32'h1234) begin
            n_err++;
            $display("FAIL fwd_bypass got %h/%h required 00001234", rf.rd_data[0], rf.rd_data[1]);
        end
        tick();
        drive_idle();
        rf.rd_addr[1] = 5'd7;
        #1;
        n_vec++;
        if (rf.rd_data[1] !== 32'h1234) begin
            n_err++;
            $display("FAIL fwd_stored got %h required 00001234", rf.rd_data[1]);
        end
    endtask

    task automatic test_same_addr();
        drive_idle();
        drive_wr(0, 5'd9, 32'h0000_AAAA, 1'b0);
        drive_wr(1, 5'd9, 32'h0000_5555, 1'b0);
        rf.rd_addr[0] = 5'd9;
        #1;
        n_vec++;
        if (rf.rd_data[0] !== 32'h5555) begin
            n_err++;
            $display("FAIL prio_bypass got %h required 00005555", rf.rd_data[0]);
        end
        tick();
        drive_idle();
        rf.rd_addr[0] = 5'd9;
        #1;
        n_vec++;
        if (rf.rd_data[0] !== 32'h5555) begin
            n_err++;
            $display("FAIL prio_stored got %h required 00005555", rf.rd_data[0]);
        end
    endtask

    task automatic test_zero_reg();
        drive_idle();
        drive_wr(1, 5'd0, 32'hFFFF_FFFF, 1'b0);
        drive_iss(5'd0);
        #1;
        n_vec++;
        if (rf.rd_data[0] !== '0 || rf.rd_busy[0] !== 1'b0) begin
            n_err++;
            $display("FAIL zero_bypass rd_data=%h rd_busy=%b required 0/0", rf.rd_data[0], rf.rd_busy[0]);
        end
        tick();
        drive_idle();
        #1;
        n_vec++;
        if (rf.rd_data[1] !== '0 || rf.busy_vec[0] !== 1'b0 || rf.rd_busy[1] !== 1'b0) begin
            n_err++;
            $display("FAIL zero_after rd_data=%h busy0=%b rd_busy=%b required 0/0/0", rf.rd_data[1], rf.busy_vec[0], rf.rd_busy[1]);
        end
    endtask

    task automatic test_scoreboard();
        drive_idle();
        drive_iss(5'd3);
        tick();
        drive_idle();
        rf.rd_addr[0] = 5'd3;
        #1;
        n_vec++;
        if (rf.rd_busy[0] !== 1'b1 || rf.busy_vec[3] !== 1'b1) begin
            n_err++;
            $display("FAIL sb_issue rd_busy=%b busy3=%b required 1/1", rf.rd_busy[0], rf.busy_vec[3]);
        end
        // write without clr leaves the hazard in place
        drive_wr(0, 5'd3, 32'h0000_0BAD, 1'b0);
        #1;
        n_vec++;
        if (rf.rd_busy[0] !== 1'b1) begin
            n_err++;
            $display("FAIL sb_noclr rd_busy=%b required 1", rf.rd_busy[0]);
        end
        tick();
        drive_idle();
        rf.rd_addr[0] = 5'd3;
        drive_wr(1, 5'd3, 32'h0000_CAFE, 1'b1);
        #1;
        n_vec++;
        if (rf.rd_busy[0] !== 1'b0 || rf.rd_data[0] !== 32'hCAFE || rf.busy_vec[3] !== 1'b1) begin
            n_err++;
            $display("FAIL sb_retire rd_busy=%b rd_data=%h busy3=%b required 0/0000cafe/1", rf.rd_busy[0], rf.rd_data[0], rf.busy_vec[3]);
        end
        tick();
        drive_idle();
        #1;
        n_vec++;
        if (rf.busy_vec[3] !== 1'b0) begin
            n_err++;
            $display("FAIL sb_cleared busy3=%b required 0", rf.busy_vec[3]);
        end
        drive_iss(5'd3);
        drive_wr(0, 5'd3, 32'h0000_0001, 1'b1);
        tick();
        drive_idle();
        #1;
        n_vec++;
        if (rf.busy_vec[3] !== 1'b1) begin
            n_err++;
            $display("FAIL sb_issue_beats_clr busy3=%b required 1", rf.busy_vec[3]);
        end
    endtask

    task automatic test_flush();
        drive_idle();
        drive_iss(5'd2);
        tick();
        drive_iss(5'd4);
        tick();
        drive_iss(5'd6);
        tick();
        drive_idle();
        #1;
        n_vec++;
        if (rf.busy_vec !== 32'h0000_005C) begin
            n_err++;
            $display("FAIL flush_pre busy_vec=%h required 0000005c", rf.busy_vec);
        end
        rf.flush = 1'b1;
        drive_iss(5'd8);
        tick();
        drive_idle();
        #1;
        n_vec++;
        if (rf.busy_vec !== '0) begin
            n_err++;
            $display("FAIL flush_all busy_vec=%h required 0", rf.busy_vec);
        end
    endtask

    task automatic test_random();
        logic [XLEN-1:0]  exp_d;
        logic [NREGS-1:0] exp_b;
        for (int c = 0; c < 400; c++) begin
            drive_idle();
            for (int i = 0; i < NWR; i++) begin
                rf.wr_en[i]   = 1'($urandom_range(1, 0));
                rf.wr_addr[i] = AW'($urandom_range(11, 0));
                rf.wr_data[i] = XLEN'($urandom);
                rf.wr_clr[i]  = 1'($urandom_range(1, 0));
            end
            for (int j = 0; j < NRD; j++) rf.rd_addr[j] = AW'($urandom_range(11, 0));
            rf.iss_en   = ($urandom_range(2, 0) == 0);
            rf.iss_addr = AW'($urandom_range(11, 0));
            rf.flush    = ($urandom_range(15, 0) == 0);
            #1;
            for (int j = 0; j < NRD; j++) exp_q.push_back(mdl_rd(rf.rd_addr[j]));
            for (int j = 0; j < NRD; j++) begin
                exp_d = exp_q.pop_front();
                n_vec++;
                if (rf.rd_data[j] !== exp_d) begin
                    n_err++;
                    $display("FAIL rand_rd_data c=%0d port=%0d addr=%0d got %h required %h", c, j, rf.rd_addr[j], rf.rd_data[j], exp_d);
                end
                n_vec++;
                if (rf.rd_busy[j] !== mdl_rbusy(rf.rd_addr[j])) begin
                    n_err++;
                    $display("FAIL rand_rd_busy c=%0d port=%0d got %b required %b", c, j, rf.rd_busy[j], mdl_rbusy(rf.rd_addr[j]));
                end
            end
            exp_b = mdl_bvec();
            n_vec++;
            if (rf.busy_vec !== exp_b) begin
                n_err++;
                $display("FAIL rand_busy_vec c=%0d got %h required %h", c, rf.busy_vec, exp_b);
            end
            tick();
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_forward();
        test_same_addr();
        test_zero_reg();
        test_scoreboard();
        test_flush();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not complete within 200000 ns");
        $fatal(1, "watchdog expired");
    end

endmodule
